frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_sched_pkg.sv | 26 ++
 rtl/frame_skid_buf.sv | 70 +++++++
 rtl/frame_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_frame_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// ----------------------------------------------------------------------------
// frame_sched_pkg: shared types and header layout for the frame scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_SEND     = 3'd3,
    ST_DONE     = 3'd4
  } sched_state_e;

  localparam int c_hdr_len   = 0;
  localparam int c_hdr_tmask = 1;
  localparam int c_hdr_wmask = 2;
  localparam int c_hdr_words = 3;
  localparam int c_len_w     = 8;

endpackage

`default_nettype wire

// File: rtl/frame_skid_buf.sv
// ----------------------------------------------------------------------------
// frame_skid_buf: 2-entry valid/ready buffer, head entry drives the output
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module frame_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_level;
  logic             w_push;
  logic             w_pop;

  assign pop_valid  = (r_level != 2'd0);
  assign pop_data   = r_head;
  assign level      = r_level;
  assign push_ready = (r_level != 2'd2) | pop_ready;
  assign w_push     = push_valid & push_ready;
  assign w_pop      = pop_valid & pop_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= 2'd0;
    end else if (flush) begin
      r_level <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_level == 2'd0) r_head <= push_data;
          else                 r_tail <= push_data;
          r_level <= r_level + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_level <= r_level - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the head advances and the new word lands behind it
          if (r_level == 2'd1) begin
            r_head <= push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_scheduler.sv
// ----------------------------------------------------------------------------
// frame_scheduler: walks the program table and streams payloads to cores
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter  int NUM_CORES   = 16,
  parameter  int WORD_W      = 16,
  parameter  int FRAME_WORDS = 64,
  parameter  int MEM_DEPTH   = 1024,
  localparam int ADDR_W      = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_loading,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic                 core_reading,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [WORD_W-1:0]    mem_rdata,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [NUM_CORES-1:0] out_core_mask,
  output logic                 frame_being_sent,
  output logic                 prog_start,
  output logic                 sched_done,
  output logic                 sched_err
);

  localparam int c_base_w = 32;

  sched_state_e         r_state;
  logic [c_base_w-1:0]  r_base;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_out_addr;
  logic [ADDR_W-1:0]    r_last_addr;
  logic [1:0]           r_hdr_cnt;
  logic [c_len_w-1:0]   r_len;
  logic [NUM_CORES-1:0] r_tmask;
  logic [NUM_CORES-1:0] r_wmask;
  logic [NUM_CORES-1:0] r_core_mask;
  logic                 r_issue_done;
  logic                 r_inflight;
  logic                 r_trunc;
  logic                 r_prog_start;
  logic                 r_fbs;
  logic                 r_done;
  logic                 r_err;

  logic [c_base_w-1:0]  w_span;
  logic [c_base_w-1:0]  w_next_base;
  logic [c_base_w-1:0]  w_end;
  logic [NUM_CORES-1:0] w_need;
  logic                 w_skid_valid;
  logic                 w_push_ready;
  logic [1:0]           w_level;
  logic [1:0]           w_occ;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_is_last;

  assign w_span      = c_base_w'(r_len) * c_base_w'(FRAME_WORDS);
  assign w_next_base = r_base + w_span;
  assign w_end       = w_next_base - c_base_w'(1);
  assign w_need      = r_wmask | r_tmask;
  assign w_pop       = w_skid_valid & core_reading;
  assign w_is_last   = w_skid_valid & (r_out_addr == r_last_addr);

  // A read is only issued if its data is guaranteed a free slot when it returns
  assign w_occ   = w_level + {1'b0, r_inflight};
  assign w_issue = (r_state == ST_SEND) && !r_issue_done && w_push_ready &&
                   ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

  frame_skid_buf #(
    .WIDTH (WORD_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (prog_loading),
    .push_valid (r_inflight),
    .push_ready (w_push_ready),
    .push_data  (mem_rdata),
    .pop_valid  (w_skid_valid),
    .pop_ready  (core_reading),
    .pop_data   (out_data),
    .level      (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_addr       <= '0;
      r_out_addr   <= '0;
      r_last_addr  <= '0;
      r_hdr_cnt    <= '0;
      r_len        <= '0;
      r_tmask      <= '0;
      r_wmask      <= '0;
      r_core_mask  <= '0;
      r_issue_done <= 1'b0;
      r_inflight   <= 1'b0;
      r_trunc      <= 1'b0;
      r_prog_start <= 1'b0;
      r_fbs        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (prog_loading) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_addr       <= '0;
      r_hdr_cnt    <= '0;
      r_core_mask  <= '0;
      r_issue_done <= 1'b0;
      r_inflight   <= 1'b0;
      r_trunc      <= 1'b0;
      r_prog_start <= 1'b0;
      r_fbs        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_prog_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_HDR;
          r_hdr_cnt <= '0;
          r_base    <= '0;
          r_addr    <= '0;
        end

        ST_HDR: begin
          if ((r_hdr_cnt == 2'd0) &&
              (r_base > c_base_w'(MEM_DEPTH - c_hdr_words))) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_hdr_cnt != 2'(c_hdr_words)) begin
            // Header word N returns one cycle after its address, hence the +1
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            r_addr    <= r_addr + ADDR_W'(1);
            if (r_hdr_cnt == 2'(c_hdr_len + 1))   r_len   <= mem_rdata[c_len_w-1:0];
            if (r_hdr_cnt == 2'(c_hdr_tmask + 1)) r_tmask <= mem_rdata[NUM_CORES-1:0];
          end else if (r_len == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_tmask == '0) begin
            r_base    <= w_next_base;
            r_addr    <= ADDR_W'(w_next_base);
            r_hdr_cnt <= '0;
          end else if (r_base + c_base_w'(c_hdr_words) >= c_base_w'(MEM_DEPTH)) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_wmask      <= mem_rdata[NUM_CORES-1:0];
            r_out_addr   <= r_addr;
            r_issue_done <= 1'b0;
            r_state      <= ST_WAIT_RDY;
            if (w_end >= c_base_w'(MEM_DEPTH)) begin
              r_err       <= 1'b1;
              r_trunc     <= 1'b1;
              r_last_addr <= ADDR_W'(MEM_DEPTH - 1);
            end else begin
              r_trunc     <= 1'b0;
              r_last_addr <= ADDR_W'(w_end);
            end
          end
        end

        ST_WAIT_RDY: begin
          if ((core_ready & w_need) == w_need) begin
            r_state      <= ST_SEND;
            r_prog_start <= 1'b1;
            r_fbs        <= 1'b1;
            r_core_mask  <= r_tmask;
          end
        end

        ST_SEND: begin
          if (w_issue) begin
            if (r_addr == r_last_addr) r_issue_done <= 1'b1;
            else                       r_addr       <= r_addr + ADDR_W'(1);
          end
          r_inflight <= w_issue;
          if (w_pop) r_out_addr <= r_out_addr + ADDR_W'(1);
          if (w_pop && w_is_last) begin
            r_fbs        <= 1'b0;
            r_core_mask  <= '0;
            r_issue_done <= 1'b0;
            if (r_trunc) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state   <= ST_HDR;
              r_base    <= w_next_base;
              r_addr    <= ADDR_W'(w_next_base);
              r_hdr_cnt <= '0;
            end
          end
        end

        ST_DONE: ;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr         = r_addr;
  assign out_valid        = w_skid_valid;
  assign out_last         = w_is_last;
  assign out_core_mask    = r_core_mask;
  assign frame_being_sent = r_fbs;
  assign prog_start       = r_prog_start;
  assign sched_done       = r_done;
  assign sched_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_frame_scheduler: directed self-checking bench for frame_scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_frame_scheduler;

  localparam int NUM_CORES   = 16;
  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = 64;
  localparam int MEM_DEPTH   = 1024;
  localparam int ADDR_W      = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 prog_loading;
  logic [NUM_CORES-1:0] core_ready;
  logic                 core_reading;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WORD_W-1:0]    mem_rdata;
  logic [WORD_W-1:0]    out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [NUM_CORES-1:0] out_core_mask;
  logic                 frame_being_sent;
  logic                 prog_start;
  logic                 sched_done;
  logic                 sched_err;

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  bit toggle_rd = 1'b0;
  bit mon_drop  = 1'b0;
  int n_starts  = 0;
  int drop_errs = 0;
  logic prev_valid   = 1'b0;
  logic prev_reading = 1'b0;

  logic [WORD_W-1:0]    rec_data [$];
  bit                   rec_last [$];
  logic [NUM_CORES-1:0] rec_mask [$];
  int                   rec_cyc  [$];

  frame_scheduler #(
    .NUM_CORES   (NUM_CORES),
    .WORD_W      (WORD_W),
    .FRAME_WORDS (FRAME_WORDS),
    .MEM_DEPTH   (MEM_DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .prog_loading     (prog_loading),
    .core_ready       (core_ready),
    .core_reading     (core_reading),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .out_core_mask    (out_core_mask),
    .frame_being_sent (frame_being_sent),
    .prog_start       (prog_start),
    .sched_done       (sched_done),
    .sched_err        (sched_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Transfers happen at the next rising edge when valid and ready are both seen here
  always @(negedge clk) begin
    if (out_valid === 1'b1 && core_reading === 1'b1) begin
      rec_data.push_back(out_data);
      rec_last.push_back(out_last);
      rec_mask.push_back(out_core_mask);
      rec_cyc.push_back(cyc);
    end
    if (prog_start === 1'b1) n_starts <= n_starts + 1;
    if (mon_drop && prev_valid && !prev_reading && out_valid !== 1'b1)
      drop_errs <= drop_errs + 1;
    prev_valid   <= (out_valid === 1'b1);
    prev_reading <= (core_reading === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [WORD_W-1:0] pat(input int a);
    logic [WORD_W-1:0] t;
    t = a[WORD_W-1:0];
    return t ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (toggle_rd) core_reading = ~core_reading;
    end
  endtask

  task automatic load_mem(input int kind);
    prog_loading = 1'b1;
    for (int a = 0; a < MEM_DEPTH; a++) mem[a] = pat(a);
    case (kind)
      1: begin
        mem[0]   = 16'd3; mem[1]   = 16'h000F; mem[2]   = 16'h000F;
        mem[192] = 16'd3; mem[193] = 16'h00F0; mem[194] = 16'h00F0;
        mem[384] = 16'h0000;
      end
      2: begin
        mem[0]   = 16'd2; mem[1]   = 16'h0000; mem[2]   = 16'h0000;
        mem[128] = 16'd1; mem[129] = 16'h0001; mem[130] = 16'h0000;
        mem[192] = 16'h0000;
      end
      default: begin
        mem[0] = 16'd20; mem[1] = 16'h0001; mem[2] = 16'h0000;
      end
    endcase
    tick(2);
    prog_loading = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (sched_done !== 1'b1 && n < max_cycles) begin
      tick(1);
      n++;
    end
    check({tag, "_done"}, sched_done, 1);
  endtask

  task automatic wait_words(input string tag, input int idx0, input int nw);
    int n;
    n = 0;
    while (rec_data.size() - idx0 < nw && n < 500) begin
      tick(1);
      n++;
    end
    check({tag, "_started"}, (rec_data.size() - idx0 >= nw), 1);
  endtask

  // Words a0..a1 expected in order, single out_last on a1, constant mask
  task automatic verify_prog(input string tag, input int idx0, input int a0,
                             input int a1, input logic [NUM_CORES-1:0] mask);
    int bad;
    int n;
    bad = 0;
    n   = a1 - a0 + 1;
    if (rec_data.size() < idx0 + n) begin
      check({tag, "_avail"}, rec_data.size() - idx0, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (rec_data[idx0+i] !== pat(a0 + i) || rec_last[idx0+i] !== (i == n - 1) ||
            rec_mask[idx0+i] !== mask)
          bad++;
      end
      check({tag, "_words"}, bad, 0);
    end
  endtask

  initial begin
    int idx0;
    int idx1;
    int s0;
    int d0;
    int t0;

    reset        = 1'b1;
    prog_loading = 1'b1;
    core_ready   = 16'hFFFF;
    core_reading = 1'b1;
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_mask", out_core_mask, 0);
    check("rst_fbs", frame_being_sent, 0);
    check("rst_start", prog_start, 0);
    check("rst_done", sched_done, 0);
    check("rst_err", sched_err, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1'b0;

    // Two programs, all cores ready, sink always ready
    idx0 = rec_data.size(); s0 = n_starts;
    load_mem(1);
    run_until_done("a", 2000);
    check("a_count", rec_data.size() - idx0, 378);
    verify_prog("a_p1", idx0, 3, 191, 16'h000F);
    verify_prog("a_p2", idx0 + 189, 195, 383, 16'h00F0);
    check("a_err", sched_err, 0);
    check("a_starts", n_starts - s0, 2);
    if (rec_cyc.size() >= idx0 + 189)
      check("a_tput", rec_cyc[idx0+188] - rec_cyc[idx0], 188);
    else
      check("a_tput_avail", rec_cyc.size() - idx0, 189);
    tick(5);
    check("a_hold_done", sched_done, 1);
    check("a_idle_valid", out_valid, 0);

    // Cores 0..3 not ready for 50 cycles
    core_ready = 16'hFFF0;
    idx0 = rec_data.size(); s0 = n_starts;
    load_mem(1);
    t0 = cyc;
    tick(50);
    check("b_held_words", rec_data.size() - idx0, 0);
    check("b_held_fbs", frame_being_sent, 0);
    core_ready = 16'hFFFF;
    run_until_done("b", 2000);
    check("b_count", rec_data.size() - idx0, 378);
    if (rec_cyc.size() > idx0)
      check("b_late_start", (rec_cyc[idx0] > t0 + 50), 1);
    verify_prog("b_p1", idx0, 3, 191, 16'h000F);
    check("b_starts", n_starts - s0, 2);

    // Sink ready toggles every cycle
    toggle_rd = 1'b1;
    mon_drop  = 1'b1;
    idx0 = rec_data.size(); d0 = drop_errs;
    load_mem(1);
    run_until_done("c", 3000);
    mon_drop  = 1'b0;
    toggle_rd = 1'b0;
    core_reading = 1'b1;
    check("c_count", rec_data.size() - idx0, 378);
    verify_prog("c_p1", idx0, 3, 191, 16'h000F);
    verify_prog("c_p2", idx0 + 189, 195, 383, 16'h00F0);
    check("c_no_drop", drop_errs - d0, 0);

    // Zero target mask skips the first program
    idx0 = rec_data.size(); s0 = n_starts;
    load_mem(2);
    run_until_done("d", 2000);
    check("d_count", rec_data.size() - idx0, 61);
    verify_prog("d_p", idx0, 131, 191, 16'h0001);
    check("d_starts", n_starts - s0, 1);
    check("d_err", sched_err, 0);

    // Program runs past the end of memory
    idx0 = rec_data.size();
    load_mem(3);
    run_until_done("e", 3000);
    check("e_count", rec_data.size() - idx0, 1021);
    verify_prog("e_p", idx0, 3, 1023, 16'h0001);
    check("e_err", sched_err, 1);

    // Load request mid-stream aborts, then restarts from address 0
    idx0 = rec_data.size();
    load_mem(1);
    wait_words("f", idx0, 20);
    prog_loading = 1'b1;
    tick(1);
    check("f_valid", out_valid, 0);
    check("f_fbs", frame_being_sent, 0);
    check("f_addr", mem_addr, 0);
    check("f_err_clr", sched_err, 0);
    tick(2);
    prog_loading = 1'b0;
    idx1 = rec_data.size();
    run_until_done("f", 2000);
    check("f_count", rec_data.size() - idx1, 378);
    verify_prog("f_p1", idx1, 3, 191, 16'h000F);

    // Reset mid-stream aborts with no further transfers
    idx0 = rec_data.size();
    load_mem(1);
    wait_words("g", idx0, 20);
    reset = 1'b1;
    tick(1);
    check("g_valid", out_valid, 0);
    check("g_mask", out_core_mask, 0);
    s0 = rec_data.size();
    tick(5);
    check("g_no_xfer", rec_data.size() - s0, 0);
    check("g_fbs", frame_being_sent, 0);
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
